// File: rtl/seq_pkg.sv
// Shared types and defaults for the parallel-to-serial bit source.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } ser_state_t;

    localparam int SER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial source: valid/ready word input, MSB-first gapless serial output.
// Optional trailing even-parity bit per frame when SEQ_SERIALIZER_PARITY_EN is defined.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

    ser_state_t       r_state;
    ser_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_in_ready;
    logic             w_xfer;
    logic             w_last_bit;

`ifdef SEQ_SERIALIZER_PARITY_EN
    logic r_par;
    logic w_par_nxt;

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    assign w_last_bit = (r_cnt == CNT_ZERO);
    assign w_xfer     = in_valid & w_in_ready;

    // Acceptance window: idle, or the final cycle of the current frame.
    always_comb begin
        w_in_ready = 1'b0;
        if (!rst) begin
            w_in_ready = 1'b0;
        end else begin
            case (r_state)
                IDLE:    w_in_ready = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
                SHIFT:   w_in_ready = 1'b0;
                PARITY:  w_in_ready = 1'b1;
`else
                SHIFT:   w_in_ready = w_last_bit;
                PARITY:  w_in_ready = 1'b0;
`endif
                default: w_in_ready = 1'b0;
            endcase
        end
    end

    // Next-state, shifter and counter update.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
`ifdef SEQ_SERIALIZER_PARITY_EN
        w_par_nxt   = r_par;
`endif
        if (w_xfer) begin
            w_state_nxt = SHIFT;
            w_shreg_nxt = in_data;
            w_cnt_nxt   = CNT_LOAD;
`ifdef SEQ_SERIALIZER_PARITY_EN
            w_par_nxt   = even_parity(in_data);
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                SHIFT: begin
                    w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                    if (w_last_bit) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = IDLE;
`endif
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt   = r_cnt - CNT_ONE;
                    end
                end
                PARITY: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_shreg_nxt = {WIDTH{1'b0}};
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, shift register and counter; reset aborts any word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shreg <= {WIDTH{1'b0}};
            r_cnt   <= CNT_ZERO;
`ifdef SEQ_SERIALIZER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef SEQ_SERIALIZER_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    // Serial outputs decoded purely from registered state.
    always_comb begin
        dout       = 1'b0;
        dout_valid = 1'b0;
        case (r_state)
            IDLE: begin
                dout       = 1'b0;
                dout_valid = 1'b0;
            end
            SHIFT: begin
                dout       = r_shreg[WIDTH-1];
                dout_valid = 1'b1;
            end
`ifdef SEQ_SERIALIZER_PARITY_EN
            PARITY: begin
                dout       = r_par;
                dout_valid = 1'b1;
            end
`endif
            default: begin
                dout       = 1'b0;
                dout_valid = 1'b0;
            end
        endcase
    end

    assign busy     = (r_state != IDLE);
    assign in_ready = w_in_ready;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer (WIDTH=8); parity scenarios follow SEQ_SERIALIZER_PARITY_EN.
module tb_seq_serializer;

`ifdef SEQ_SERIALIZER_PARITY_EN
    localparam int FR = 9;
`else
    localparam int FR = 8;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       dout;
    logic       dout_valid;
    logic       busy;

    int n_checks;
    int n_pass;

    seq_serializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_bit(input logic [7:0] w, input int k);
        if (k < 8) return w[7-k];
        else       return ^w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 8'h81;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({in_ready, dout, dout_valid, busy} !== 4'b0000)
                $display("FAIL reset_outs[%0d]: got %b want 0000", i, {in_ready, dout, dout_valid, busy});
            else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({in_ready, dout_valid, busy} !== 3'b100)
                $display("FAIL reset_idle[%0d]: got %b want 100", i, {in_ready, dout_valid, busy});
            else n_pass++;
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        w = 8'hD5;
        in_data = w; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 8'h00;
        for (int k = 0; k < FR; k++) begin
            n_checks++;
            if ({dout_valid, dout} !== {1'b1, exp_bit(w, k)})
                $display("FAIL single_bit[%0d]: got %b want %b", k, {dout_valid, dout}, {1'b1, exp_bit(w, k)});
            else n_pass++;
            tick();
        end
        n_checks++;
        if ({dout_valid, busy, dout, in_ready} !== 4'b0001)
            $display("FAIL single_end: got %b want 0001", {dout_valid, busy, dout, in_ready});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] w0, w1, w;
        w0 = 8'hD0; w1 = 8'h0D;
        in_data = w0; in_valid = 1'b1;
        tick();
        in_data = w1;
        for (int k = 0; k < 2 * FR; k++) begin
            w = (k < FR) ? w0 : w1;
            n_checks++;
            if ({dout_valid, dout} !== {1'b1, exp_bit(w, k % FR)})
                $display("FAIL b2b_bit[%0d]: got %b want %b", k, {dout_valid, dout}, {1'b1, exp_bit(w, k % FR)});
            else n_pass++;
            n_checks++;
            if (in_ready !== ((k % FR) == FR - 1))
                $display("FAIL b2b_ready[%0d]: got %b want %b", k, in_ready, ((k % FR) == FR - 1));
            else n_pass++;
            if (k == FR) in_valid = 1'b0;
            tick();
        end
        n_checks++;
        if ({dout_valid, busy} !== 2'b00)
            $display("FAIL b2b_end: got %b want 00", {dout_valid, busy});
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] w0, w1;
        w0 = 8'h3C; w1 = 8'hAA;
        in_data = w0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < FR; k++) begin
            if (k == 2) begin
                in_valid = 1'b1; in_data = w1;
            end
            n_checks++;
            if ({dout_valid, dout} !== {1'b1, exp_bit(w0, k)})
                $display("FAIL bp_first[%0d]: got %b want %b", k, {dout_valid, dout}, {1'b1, exp_bit(w0, k)});
            else n_pass++;
            if (k >= 2) begin
                n_checks++;
                if (in_ready !== (k == FR - 1))
                    $display("FAIL bp_ready[%0d]: got %b want %b", k, in_ready, (k == FR - 1));
                else n_pass++;
            end
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < FR; k++) begin
            n_checks++;
            if ({dout_valid, dout} !== {1'b1, exp_bit(w1, k)})
                $display("FAIL bp_second[%0d]: got %b want %b", k, {dout_valid, dout}, {1'b1, exp_bit(w1, k)});
            else n_pass++;
            tick();
        end
        n_checks++;
        if ({dout_valid, busy} !== 2'b00)
            $display("FAIL bp_end: got %b want 00", {dout_valid, busy});
        else n_pass++;
    endtask

    task automatic test_reset_mid_word();
        in_data = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if ({dout_valid, dout, busy} !== 3'b111)
            $display("FAIL rmw_before: got %b want 111", {dout_valid, dout, busy});
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, dout, dout_valid, busy} !== 4'b0000)
            $display("FAIL rmw_async: got %b want 0000", {in_ready, dout, dout_valid, busy});
        else n_pass++;
        tick();
        rst = 1'b1;
        for (int i = 0; i < FR + 2; i++) begin
            tick();
            n_checks++;
            if ({dout_valid, dout, busy} !== 3'b000)
                $display("FAIL rmw_residual[%0d]: got %b want 000", i, {dout_valid, dout, busy});
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
